// File: rtl/ctr_record_reader_pkg.sv
// Shared types and constants for the control-transfer-record read path.
// Holds the transfer-type encoding, per-entry metadata layout and CSR select codes.
package ctr_record_reader_pkg;

  localparam logic [11:0] CTR_SISELECT_BASE = 12'h200;
  localparam int unsigned CTR_CC_W          = 16;

  localparam logic [1:0] CTR_SEL_SOURCE = 2'd0;
  localparam logic [1:0] CTR_SEL_TARGET = 2'd1;
  localparam logic [1:0] CTR_SEL_DATA   = 2'd2;

  typedef enum logic [3:0] {
    CTR_TYPE_NONE        = 4'd0,
    CTR_TYPE_EXC         = 4'd1,
    CTR_TYPE_INTR        = 4'd2,
    CTR_TYPE_TRET        = 4'd3,
    CTR_TYPE_NTBR        = 4'd4,
    CTR_TYPE_TKBR        = 4'd5,
    CTR_TYPE_RSVD6       = 4'd6,
    CTR_TYPE_RSVD7       = 4'd7,
    CTR_TYPE_INDCALL     = 4'd8,
    CTR_TYPE_DIRCALL     = 4'd9,
    CTR_TYPE_INDJUMP     = 4'd10,
    CTR_TYPE_DIRJUMP     = 4'd11,
    CTR_TYPE_CORSWAP     = 4'd12,
    CTR_TYPE_RET         = 4'd13,
    CTR_TYPE_INDLJUMP    = 4'd14,
    CTR_TYPE_DIRLJUMP    = 4'd15
  } ctr_type_t;

  typedef struct packed {
    ctr_type_t             ctype;
    logic [CTR_CC_W-1:0]   cc;
    logic                  ccv;
  } ctr_meta_t;

  // ctrdata layout: CC in [31:16], CCV in [15], TYPE in [3:0].
  function automatic logic [31:0] ctr_pack_data(input ctr_meta_t meta);
    return {meta.cc, meta.ccv, 11'd0, meta.ctype};
  endfunction

endpackage

// File: rtl/ctr_record_reader_cycle_counter.sv
// Saturating 16-bit idle-cycle counter for record CC fields.
// Only instantiated when CTR_CYCLE_COUNT_EN is defined.
module ctr_cycle_counter
  import ctr_record_reader_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                hold_i,
  input  logic                clr_i,
  output logic [CTR_CC_W-1:0] cnt_o,
  output logic                sat_o
);

  logic [CTR_CC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!hold_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CTR_CC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = &cnt_q;

endmodule

// File: rtl/ctr_record_reader.sv
// Circular control-transfer-record buffer with registered indirect-CSR reads.
// Define CTR_CYCLE_COUNT_EN to record idle-cycle counts (CC/CCV) per entry.
module ctr_record_reader
  import ctr_record_reader_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned CtrDepth = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        rec_valid_i,
  input  logic [XLEN-1:0]             rec_source_i,
  input  logic [XLEN-1:0]             rec_target_i,
  input  logic [3:0]                  rec_type_i,
  input  logic                        freeze_i,
  input  logic                        clear_i,
  input  logic                        csr_req_i,
  input  logic [7:0]                  csr_idx_i,
  input  logic [1:0]                  csr_sel_i,
  output logic                        csr_rvalid_o,
  output logic [XLEN-1:0]             csr_rdata_o,
  output logic [$clog2(CtrDepth)-1:0] wrptr_o
);

  localparam int unsigned PTR_W = $clog2(CtrDepth);

  logic [PTR_W-1:0]    wrptr_q, wrptr_d;
  logic [CtrDepth-1:0] valid_q, valid_d;
  logic                rvalid_q, rvalid_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;

  logic [XLEN-1:0] src_mem_q  [CtrDepth];
  logic [XLEN-1:0] tgt_mem_q  [CtrDepth];
  ctr_meta_t       meta_mem_q [CtrDepth];

  logic       wr_en;
  ctr_meta_t  wr_meta;
  logic [PTR_W-1:0] rd_phys;
  ctr_meta_t  rd_meta;
  logic       rd_hit;

  assign wr_en = rec_valid_i && !freeze_i && !clear_i;

`ifdef CTR_CYCLE_COUNT_EN
  logic [CTR_CC_W-1:0] cc_val;
  logic                cc_sat;

  ctr_cycle_counter u_cycle_counter (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .hold_i (freeze_i),
    .clr_i  (wr_en || clear_i),
    .cnt_o  (cc_val),
    .sat_o  (cc_sat)
  );

  always_comb begin
    wr_meta       = '0;
    wr_meta.ctype = ctr_type_t'(rec_type_i);
    wr_meta.cc    = cc_val;
    wr_meta.ccv   = !cc_sat;
  end
`else
  always_comb begin
    wr_meta       = '0;
    wr_meta.ctype = ctr_type_t'(rec_type_i);
  end
`endif

  always_comb begin
    wrptr_d = wrptr_q;
    valid_d = valid_q;
    if (clear_i) begin
      wrptr_d = '0;
      valid_d = '0;
    end else if (wr_en) begin
      wrptr_d          = wrptr_q + PTR_W'(1);
      valid_d[wrptr_q] = 1'b1;
    end
  end

  // Reads see only pre-edge state, so a same-cycle write or clear is invisible.
  always_comb begin
    rd_phys  = wrptr_q - PTR_W'(1) - csr_idx_i[PTR_W-1:0];
    rd_meta  = meta_mem_q[rd_phys];
    rd_hit   = csr_req_i && (32'(csr_idx_i) < CtrDepth) && valid_q[rd_phys];
    rvalid_d = csr_req_i;
    rdata_d  = '0;
    if (rd_hit) begin
      unique case (csr_sel_i)
        CTR_SEL_SOURCE: rdata_d = src_mem_q[rd_phys];
        CTR_SEL_TARGET: rdata_d = tgt_mem_q[rd_phys];
        CTR_SEL_DATA:   rdata_d = XLEN'(ctr_pack_data(rd_meta));
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wrptr_q  <= '0;
      valid_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wrptr_q  <= wrptr_d;
      valid_q  <= valid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Payload storage needs no reset: every read is gated by the valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      src_mem_q[wrptr_q]  <= rec_source_i | XLEN'(1);
      tgt_mem_q[wrptr_q]  <= rec_target_i;
      meta_mem_q[wrptr_q] <= wr_meta;
    end
  end

  assign csr_rvalid_o = rvalid_q;
  assign csr_rdata_o  = rdata_q;
  assign wrptr_o      = wrptr_q;

endmodule

// File: tb/tb_ctr_record_reader.sv
// Self-checking bench for ctr_record_reader: queue-based reference model plus directed reads.
// Define CTR_CYCLE_COUNT_EN to also exercise the cycle-count fields.
module tb_ctr_record_reader;

  localparam int DEPTH = 16;
`ifdef CTR_CYCLE_COUNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        rec_valid_i = 1'b0;
  logic [63:0] rec_source_i = '0;
  logic [63:0] rec_target_i = '0;
  logic [3:0]  rec_type_i = '0;
  logic        freeze_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        csr_req_i = 1'b0;
  logic [7:0]  csr_idx_i = '0;
  logic [1:0]  csr_sel_i = '0;
  logic        csr_rvalid_o;
  logic [63:0] csr_rdata_o;
  logic [3:0]  wrptr_o;

  ctr_record_reader #(.XLEN(64), .CtrDepth(DEPTH)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .rec_valid_i  (rec_valid_i),
    .rec_source_i (rec_source_i),
    .rec_target_i (rec_target_i),
    .rec_type_i   (rec_type_i),
    .freeze_i     (freeze_i),
    .clear_i      (clear_i),
    .csr_req_i    (csr_req_i),
    .csr_idx_i    (csr_idx_i),
    .csr_sel_i    (csr_sel_i),
    .csr_rvalid_o (csr_rvalid_o),
    .csr_rdata_o  (csr_rdata_o),
    .wrptr_o      (wrptr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: youngest record at the front of a queue.
  typedef struct {
    logic [63:0] src;
    logic [63:0] tgt;
    logic [3:0]  typ;
    int          cc;
    bit          ccv;
  } rec_t;

  rec_t        hist[$];
  int          m_wrcnt = 0;
  int          m_cc = 0;
  logic        exp_rvalid = 1'b0;
  logic [63:0] exp_rdata = '0;

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hist.delete();
      m_wrcnt    = 0;
      m_cc       = 0;
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
    end else begin
      exp_rvalid = csr_req_i;
      exp_rdata  = '0;
      if (csr_req_i && int'(csr_idx_i) < hist.size()) begin
        case (csr_sel_i)
          2'd0: exp_rdata = hist[csr_idx_i].src;
          2'd1: exp_rdata = hist[csr_idx_i].tgt;
          2'd2: exp_rdata = {32'd0, 16'(hist[csr_idx_i].cc), hist[csr_idx_i].ccv, 11'd0,
                             hist[csr_idx_i].typ};
          default: exp_rdata = '0;
        endcase
      end
      if (clear_i) begin
        hist.delete();
        m_wrcnt = 0;
        m_cc    = 0;
      end else if (rec_valid_i && !freeze_i) begin
        rec_t r;
        r.src = rec_source_i | 64'h1;
        r.tgt = rec_target_i;
        r.typ = rec_type_i;
        r.cc  = CC_EN ? m_cc : 0;
        r.ccv = CC_EN ? (m_cc != 65535) : 1'b0;
        hist.push_front(r);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        m_wrcnt = (m_wrcnt + 1) % DEPTH;
        m_cc    = 0;
      end else if (!freeze_i && m_cc < 65535) begin
        m_cc++;
      end
    end
  end

  always @(negedge clk_i) begin
    if (rstn_i) begin
      chk("model_rvalid", {63'd0, csr_rvalid_o}, {63'd0, exp_rvalid});
      chk("model_rdata", csr_rdata_o, exp_rdata);
      chk("model_wrptr", {60'd0, wrptr_o}, 64'(m_wrcnt));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [63:0] src, input logic [63:0] tgt, input logic [3:0] typ);
    rec_valid_i  = 1'b1;
    rec_source_i = src;
    rec_target_i = tgt;
    rec_type_i   = typ;
    tick();
    rec_valid_i  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] idx, input logic [1:0] sel, input logic [63:0] exp,
                    input string name);
    csr_req_i = 1'b1;
    csr_idx_i = idx;
    csr_sel_i = sel;
    tick();
    csr_req_i = 1'b0;
    chk({name, "_rvalid"}, {63'd0, csr_rvalid_o}, 64'd1);
    chk(name, csr_rdata_o, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #12 rstn_i = 1'b1;
    tick();

    // 1: reset state
    chk("reset_rvalid", {63'd0, csr_rvalid_o}, 64'd0);
    chk("reset_rdata", csr_rdata_o, 64'd0);
    rd(0, 0, 64'h0, "t1_src");
    rd(0, 1, 64'h0, "t1_tgt");
    rd(0, 2, 64'h0, "t1_data");
    chk("t1_wrptr", {60'd0, wrptr_o}, 64'd0);

    // 2: three writes
    wr(64'h1000, 64'h1100, 4'd5);
    wr(64'h2000, 64'h2100, 4'd5);
    wr(64'h3000, 64'h3100, 4'd5);
    rd(0, 0, 64'h3001, "t2_idx0_src");
    rd(2, 0, 64'h1001, "t2_idx2_src");
    rd(3, 0, 64'h0, "t2_idx3_src");
    rd(0, 1, 64'h3100, "t2_idx0_tgt");
    rd(0, 2, CC_EN ? 64'h8005 : 64'h5, "t2_idx0_data");
    rd(0, 3, 64'h0, "t2_sel3");
    chk("t2_wrptr", {60'd0, wrptr_o}, 64'd3);

    // 3: wrap past the buffer depth
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int k = 1; k <= 18; k++) wr(64'(k) * 64'h100, 64'(k), 4'd9);
    chk("t3_wrptr", {60'd0, wrptr_o}, 64'd2);
    rd(15, 0, 64'h301, "t3_idx15_src");
    rd(16, 0, 64'h0, "t3_idx16_src");
    rd(0, 0, 64'h1201, "t3_idx0_src");
    rd(255, 1, 64'h0, "t3_idx255_tgt");
    csr_req_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      csr_idx_i = 8'(i);
      csr_sel_i = 2'(i % 3);
      tick();
    end
    csr_req_i = 1'b0;

    // 4: freeze drops writes, then clear beats a simultaneous write
    freeze_i = 1'b1;
    for (int k = 0; k < 4; k++) wr(64'hA000 + 64'(k) * 64'h10, 64'h0, 4'd1);
    chk("t4_frozen_wrptr", {60'd0, wrptr_o}, 64'd2);
    rd(0, 0, 64'h1201, "t4_frozen_idx0");
    freeze_i = 1'b0;
    clear_i  = 1'b1;
    wr(64'hB000, 64'hB100, 4'd2);
    clear_i  = 1'b0;
    chk("t4_clear_wrptr", {60'd0, wrptr_o}, 64'd0);
    rd(0, 0, 64'h0, "t4_clear_idx0_src");
    rd(0, 2, 64'h0, "t4_clear_idx0_data");
    rd(15, 1, 64'h0, "t4_clear_idx15_tgt");

    // 5: same-cycle read and write, then same-cycle read and clear
    wr(64'h4000, 64'h4100, 4'd11);
    csr_req_i = 1'b1;
    csr_idx_i = 8'd0;
    csr_sel_i = 2'd0;
    wr(64'h5000, 64'h5100, 4'd11);
    csr_req_i = 1'b0;
    chk("t5_rw_same_cycle", csr_rdata_o, 64'h4001);
    rd(0, 0, 64'h5001, "t5_next_idx0");
    csr_req_i = 1'b1;
    clear_i   = 1'b1;
    tick();
    csr_req_i = 1'b0;
    clear_i   = 1'b0;
    chk("t5_rc_same_cycle", csr_rdata_o, 64'h5001);
    rd(0, 0, 64'h0, "t5_after_clear");

`ifdef CTR_CYCLE_COUNT_EN
    // 6: cycle counts, freeze hold and saturation
    wr(64'h6000, 64'h6100, 4'd8);
    idle(10);
    wr(64'h7000, 64'h7100, 4'd9);
    rd(0, 2, 64'h000A_8009, "t6_cc10");
    freeze_i = 1'b1;
    idle(5);
    freeze_i = 1'b0;
    idle(2);
    wr(64'h7800, 64'h7900, 4'd10);
    rd(0, 2, 64'h0003_800A, "t6_cc_frozen");
    idle(70000);
    wr(64'h8000, 64'h8100, 4'd13);
    rd(0, 2, 64'hFFFF_000D, "t6_cc_sat");
`endif

    // Reset asserted with a read in flight
    wr(64'h9000, 64'h9100, 4'd3);
    csr_req_i = 1'b1;
    csr_idx_i = 8'd0;
    csr_sel_i = 2'd0;
    tick();
    csr_req_i = 1'b0;
    chk("rst_pre_rvalid", {63'd0, csr_rvalid_o}, 64'd1);
    chk("rst_pre_rdata", csr_rdata_o, 64'h9001);
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_rvalid", {63'd0, csr_rvalid_o}, 64'd0);
    chk("rst_mid_rdata", csr_rdata_o, 64'd0);
    chk("rst_mid_wrptr", {60'd0, wrptr_o}, 64'd0);
    #1 rstn_i = 1'b1;
    tick();
    rd(0, 0, 64'h0, "rst_after_idx0");

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ctr_record_reader.md
Name: ctr_record_reader

Overview:
- CSR-side read end of the Control Transfer Records (Smctr/Ssctr) path.
- Stores committed transfer records in a circular buffer and serves indirect-CSR reads (siselect 0x200-0x2FF → sireg/sireg2/sireg3 = ctrsource/ctrtarget/ctrdata) from csr_regfile.
- Also handles the SCTRCLR clear and the freeze control, and exports the SCTRSTATUS.WRPTR field.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; XLEN sets record width.
- CtrDepth, 16, number of record entries; power of two, 16..256.

Ports:
- clk_i  in  1  subsystem clock
- rstn_i  in  1  asynchronous reset, active low
- rec_valid_i  in  1  one qualified record this cycle, from the commit-side logger
- rec_source_i  in  XLEN  source PC; bit0 = V (entry valid) is forced to 1 on write
- rec_target_i  in  XLEN  target PC; bit0 = MISP
- rec_type_i  in  4  riscv::ctr_type_t transfer type
- freeze_i  in  1  SCTRSTATUS.FROZEN; blocks writes
- clear_i  in  1  SCTRCLR pulse
- csr_req_i  in  1  indirect read request
- csr_idx_i  in  8  logical entry index (siselect - 0x200); 0 = youngest
- csr_sel_i  in  2  0 = ctrsource, 1 = ctrtarget, 2 = ctrdata, 3 = reserved
- csr_rvalid_o  out  1  read data valid
- csr_rdata_o  out  XLEN  read data
- wrptr_o  out  $clog2(CtrDepth)  SCTRSTATUS.WRPTR

Behaviour:
- Reset:
  - All entries invalid (V = 0); wrptr_o = 0.
  - csr_rvalid_o = 0, csr_rdata_o = 0.
  - Cycle counter = 0.
- Write, when rec_valid_i && !freeze_i && !clear_i:
  - entry[wrptr] <= {source | 1, target, type, cc}.
  - wrptr <= wrptr + 1, wrapping modulo CtrDepth.
  - When the buffer is full, the oldest entry is overwritten silently; there is no full flag.
- Freeze: while freeze_i = 1, writes are dropped and the cycle counter holds.
- Clear:
  - clear_i = 1 sets every V to 0, wrptr <= 0, and cycle counter <= 0.
  - A write in the same cycle is dropped; clear wins.
- Read:
  - One-cycle latency. A request in cycle N produces csr_rvalid_o = 1 and csr_rdata_o in cycle N+1.
  - With no request, csr_rvalid_o = 0 and csr_rdata_o = 0.
  - Physical index = (wrptr - 1 - csr_idx_i) mod CtrDepth, computed from wrptr as it stands in cycle N.
  - Result is 0 when csr_idx_i >= CtrDepth, when the entry has V = 0, or when csr_sel_i = 3.
  - ctrsource returns the stored source with V at bit0.
  - ctrtarget returns the stored target.
  - ctrdata = {XLEN-32 zeros, CC[31:16], CCV[15], 11 zeros, TYPE[3:0]}.
- Same-cycle read and write:
  - The read sees the pre-edge buffer and the pre-edge wrptr.
  - Example: logical idx 0 returns the previous youngest record, not the one being written.
- Same-cycle read and clear: the read returns pre-clear data; reads issued from the next cycle on return 0.
- Back-to-back requests: accepted every cycle, no stall.
- Reset asserted mid-read: csr_rvalid_o drops to 0 asynchronously; no pending read survives reset.

Optional Feature:
- Macro: CTR_CYCLE_COUNT_EN.
- When defined:
  - A 16-bit counter increments each non-frozen cycle, saturating at 0xFFFF.
  - It resets to 0 on every accepted write.
  - The value before the reset is stored as CC in the new entry.
  - CCV = 1 unless the counter was saturated.
- When undefined: no counter; CC = 0 and CCV = 0 in every entry.

Decomposition:
- ariane_pkg holds:
  - ctr_entry_t (source, target, type, cc, ccv)
  - CTR_SISELECT_BASE = 0x200
  - the CTR_SEL_SOURCE / CTR_SEL_TARGET / CTR_SEL_DATA encodings
- riscv::ctr_type_t is reused unchanged.
- One natural sub-module: ctr_cycle_counter, the saturating counter, instantiated only under CTR_CYCLE_COUNT_EN.

Test Plan:
1. Reset, then read idx 0 with sel 0, 1 and 2 → rvalid = 1 one cycle later, rdata = 0 each time; wrptr_o = 0.
2. Write 3 records with sources 0x1000/0x2000/0x3000 → idx 0 source = 0x3001, idx 2 source = 0x1001, idx 3 = 0; wrptr_o = 3.
3. Write 18 records into CtrDepth = 16 (sources 0x100*k, k = 1..18) → wrptr_o = 2; idx 15 source = 0x301; idx 16 = 0 (out of range).
4. freeze_i = 1 with 4 writes → wrptr_o unchanged and contents unchanged. Then clear_i together with rec_valid_i → wrptr_o = 0 and all reads = 0.
5. Read idx 0 in the same cycle as a write of 0x5000, previous youngest 0x4000 → rdata = 0x4001. A read of idx 0 in the next cycle → 0x5001.
6. With CTR_CYCLE_COUNT_EN defined, write, idle 10 unfrozen cycles, write again → the second entry's ctrdata has CC = 10, CCV = 1, TYPE matching. Idle 70000 cycles, then write → CC = 0xFFFF, CCV = 0.
